// File: rtl/fpall_pkg.sv
// rtl/fpall_pkg.sv - shared types for the FP32 / dual-BF16 adder datapath
package fpall_pkg;

  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;

endpackage

// File: rtl/fp_add_align_prep.sv
// rtl/fp_add_align_prep.sv - alignment-prep pipeline for the FP32 / dual-BF16 adder
// S1 decodes and magnitude-compares each lane; S2 swaps, clamps the shift and packs X/S.
module fp_add_align_prep
  import fpall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  fp_fmt_e     in_fmt,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output fp_fmt_e     out_fmt,
  output logic [23:0] out_x,
  output logic [7:0]  out_s,
  output logic [23:0] out_big_frac,
  output logic [15:0] out_big_exp,
  output logic [1:0]  out_sign,
  output logic [1:0]  out_eff_sub,
  output logic [1:0]  out_nan,
  output logic [1:0]  out_inf
);

  typedef struct packed {
    logic [7:0]  e;
    logic [23:0] m;
    logic        sgn;
    logic        nan;
    logic        inf;
  } lane_t;

  // BF16 fractions arrive zero-extended so the 24-bit compare key works for both formats.
  function automatic lane_t decode(input logic [7:0] e, input logic [22:0] f,
                                   input logic bf16, input logic sgn);
    lane_t l;
    logic  hid;
    hid   = (e != 8'd0);
    l.e   = hid ? e : 8'd1;
    l.m   = bf16 ? {16'd0, hid, f[6:0]} : {hid, f};
    l.sgn = sgn;
    l.nan = (&e) && (|f);
    l.inf = (&e) && !(|f);
    return l;
  endfunction

  logic        s1_valid_q, s2_valid_q;
  logic        s1_en, s2_en;

  lane_t [1:0] dec_a, dec_b;
  logic        s1_fmt16_d;
  logic [15:0] s1_ea_d, s1_eb_d;
  logic [23:0] s1_ma_d, s1_mb_d;
  logic [1:0]  s1_sa_d, s1_sb_d, s1_abig_d, s1_nan_d, s1_inf_d;

  fp_fmt_e     s1_fmt_q;
  logic [15:0] s1_ea_q, s1_eb_q;
  logic [23:0] s1_ma_q, s1_mb_q;
  logic [1:0]  s1_sa_q, s1_sb_q, s1_abig_q, s1_nan_q, s1_inf_q;

  assign s2_en    = !s2_valid_q | out_ready;
  assign s1_en    = !s1_valid_q | s2_en;
  assign in_ready = s1_en;

  always_comb begin
    s1_fmt16_d = (in_fmt == FP16);
    dec_a[1] = decode(in_a[30:23], {16'd0, in_a[22:16]}, 1'b1, in_a[31]);
    dec_b[1] = decode(in_b[30:23], {16'd0, in_b[22:16]}, 1'b1, in_b[31] ^ in_sub);
    if (s1_fmt16_d) begin
      dec_a[0] = decode(in_a[14:7], {16'd0, in_a[6:0]}, 1'b1, in_a[15]);
      dec_b[0] = decode(in_b[14:7], {16'd0, in_b[6:0]}, 1'b1, in_b[15] ^ in_sub);
    end else begin
      dec_a[0] = decode(in_a[30:23], in_a[22:0], 1'b0, in_a[31]);
      dec_b[0] = decode(in_b[30:23], in_b[22:0], 1'b0, in_b[31] ^ in_sub);
    end
    for (int l = 0; l < 2; l++) begin
      s1_abig_d[l] = {dec_a[l].e, dec_a[l].m} >= {dec_b[l].e, dec_b[l].m};
      s1_sa_d[l]   = dec_a[l].sgn;
      s1_sb_d[l]   = dec_b[l].sgn;
      s1_nan_d[l]  = dec_a[l].nan | dec_b[l].nan;
      s1_inf_d[l]  = (dec_a[l].inf | dec_b[l].inf) & !s1_nan_d[l];
    end
    if (!s1_fmt16_d) begin
      s1_nan_d[1] = 1'b0;
      s1_inf_d[1] = 1'b0;
    end
    s1_ea_d = {dec_a[1].e, dec_a[0].e};
    s1_eb_d = {dec_b[1].e, dec_b[0].e};
    // Mantissas are held already in output packing so S2 only needs per-byte selects.
    s1_ma_d = s1_fmt16_d ? {dec_a[1].m[7:0], 8'd0, dec_a[0].m[7:0]} : dec_a[0].m;
    s1_mb_d = s1_fmt16_d ? {dec_b[1].m[7:0], 8'd0, dec_b[0].m[7:0]} : dec_b[0].m;
  end

  logic        s2_fmt16, s2_hi_abig;
  logic [7:0]  ebig [2];
  logic [7:0]  esml [2];
  logic [7:0]  diff [2];
  logic [23:0] s2_x_d, s2_frac_d;
  logic [7:0]  s2_s_d;
  logic [15:0] s2_exp_d;
  logic [1:0]  s2_sign_d, s2_eff_d;

  fp_fmt_e     s2_fmt_q;
  logic [23:0] s2_x_q, s2_frac_q;
  logic [7:0]  s2_s_q;
  logic [15:0] s2_exp_q;
  logic [1:0]  s2_sign_q, s2_eff_q, s2_nan_q, s2_inf_q;

  always_comb begin
    s2_fmt16   = (s1_fmt_q == FP16);
    s2_hi_abig = s2_fmt16 ? s1_abig_q[1] : s1_abig_q[0];
    for (int l = 0; l < 2; l++) begin
      ebig[l]      = s1_abig_q[l] ? s1_ea_q[8*l +: 8] : s1_eb_q[8*l +: 8];
      esml[l]      = s1_abig_q[l] ? s1_eb_q[8*l +: 8] : s1_ea_q[8*l +: 8];
      diff[l]      = ebig[l] - esml[l];
      s2_sign_d[l] = s1_abig_q[l] ? s1_sa_q[l] : s1_sb_q[l];
      s2_eff_d[l]  = s1_sa_q[l] ^ s1_sb_q[l];
    end
    s2_x_d    = {s2_hi_abig ? s1_mb_q[23:16] : s1_ma_q[23:16],
                 s1_abig_q[0] ? s1_mb_q[15:0] : s1_ma_q[15:0]};
    s2_frac_d = {s2_hi_abig ? s1_ma_q[23:16] : s1_mb_q[23:16],
                 s1_abig_q[0] ? s1_ma_q[15:0] : s1_mb_q[15:0]};
    if (s2_fmt16) begin
      s2_s_d   = {(diff[1] > 8'd15) ? 4'hF : diff[1][3:0],
                  (diff[0] > 8'd15) ? 4'hF : diff[0][3:0]};
      s2_exp_d = {ebig[1], ebig[0]};
    end else begin
      s2_s_d       = {3'd0, (diff[0] > 8'd31) ? 5'd31 : diff[0][4:0]};
      s2_exp_d     = {8'd0, ebig[0]};
      s2_sign_d[1] = 1'b0;
      s2_eff_d[1]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= FP32;
      s1_ea_q    <= '0;
      s1_eb_q    <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s1_sa_q    <= '0;
      s1_sb_q    <= '0;
      s1_abig_q  <= '0;
      s1_nan_q   <= '0;
      s1_inf_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_fmt_q   <= FP32;
      s2_x_q     <= '0;
      s2_frac_q  <= '0;
      s2_s_q     <= '0;
      s2_exp_q   <= '0;
      s2_sign_q  <= '0;
      s2_eff_q   <= '0;
      s2_nan_q   <= '0;
      s2_inf_q   <= '0;
    end else begin
      if (s1_en) s1_valid_q <= in_valid;
      if (s1_en && in_valid) begin
        s1_fmt_q  <= in_fmt;
        s1_ea_q   <= s1_ea_d;
        s1_eb_q   <= s1_eb_d;
        s1_ma_q   <= s1_ma_d;
        s1_mb_q   <= s1_mb_d;
        s1_sa_q   <= s1_sa_d;
        s1_sb_q   <= s1_sb_d;
        s1_abig_q <= s1_abig_d;
        s1_nan_q  <= s1_nan_d;
        s1_inf_q  <= s1_inf_d;
      end
      if (s2_en) s2_valid_q <= s1_valid_q;
      if (s2_en && s1_valid_q) begin
        s2_fmt_q  <= s1_fmt_q;
        s2_x_q    <= s2_x_d;
        s2_frac_q <= s2_frac_d;
        s2_s_q    <= s2_s_d;
        s2_exp_q  <= s2_exp_d;
        s2_sign_q <= s2_sign_d;
        s2_eff_q  <= s2_eff_d;
        s2_nan_q  <= s1_nan_q;
        s2_inf_q  <= s1_inf_q;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_fmt      = s2_fmt_q;
  assign out_x        = s2_x_q;
  assign out_s        = s2_s_q;
  assign out_big_frac = s2_frac_q;
  assign out_big_exp  = s2_exp_q;
  assign out_sign     = s2_sign_q;
  assign out_eff_sub  = s2_eff_q;
  assign out_nan      = s2_nan_q;
  assign out_inf      = s2_inf_q;

endmodule

// File: tb/tb_fp_add_align_prep.sv
// tb/tb_fp_add_align_prep.sv - self-checking bench for fp_add_align_prep
module tb_fp_add_align_prep;
  import fpall_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  fp_fmt_e     in_fmt = FP32;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  fp_fmt_e     out_fmt;
  logic [23:0] out_x;
  logic [7:0]  out_s;
  logic [23:0] out_big_frac;
  logic [15:0] out_big_exp;
  logic [1:0]  out_sign, out_eff_sub, out_nan, out_inf;

  fp_add_align_prep dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_fmt(out_fmt),
    .out_x(out_x), .out_s(out_s), .out_big_frac(out_big_frac),
    .out_big_exp(out_big_exp), .out_sign(out_sign), .out_eff_sub(out_eff_sub),
    .out_nan(out_nan), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fmt;
    logic [23:0] x;
    logic [7:0]  s;
    logic [23:0] bf;
    logic [15:0] be;
    logic [1:0]  sign, eff, nan, inf;
  } beat_t;

  beat_t sb_q[$];
  int checks = 0;
  int errors = 0;

  logic        snap_valid, snap_in_ready;
  logic [23:0] snap_x, snap_bf;
  logic [7:0]  snap_s;
  logic [15:0] snap_be;
  logic [1:0]  snap_sign, snap_eff, snap_nan, snap_inf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: integer arithmetic straight from the field definitions.
  function automatic beat_t model(input logic fmt, input logic [31:0] a,
                                  input logic [31:0] b, input logic sub);
    beat_t r;
    int nl, fw, cap;
    int ea, eb, fa, fb, sa, sbv, effa, effb, ma, mb, d, bm, smm, bexp;
    bit abig, na, nb;
    logic [31:0] ha, hb;
    nl  = fmt ? 2 : 1;
    fw  = fmt ? 7 : 23;
    cap = fmt ? 15 : 31;
    r.fmt = fmt; r.x = '0; r.s = '0; r.bf = '0; r.be = '0;
    r.sign = '0; r.eff = '0; r.nan = '0; r.inf = '0;
    for (int l = 0; l < nl; l++) begin
      ha   = a >> (16 * l);
      hb   = b >> (16 * l);
      ea   = int'((ha >> fw) & 32'hFF);
      eb   = int'((hb >> fw) & 32'hFF);
      fa   = int'(ha & ((32'd1 << fw) - 1));
      fb   = int'(hb & ((32'd1 << fw) - 1));
      sa   = int'((ha >> (fw + 8)) & 32'd1);
      sbv  = int'((hb >> (fw + 8)) & 32'd1) ^ int'(sub);
      effa = (ea == 0) ? 1 : ea;
      effb = (eb == 0) ? 1 : eb;
      ma   = fa + ((ea != 0) ? (1 << fw) : 0);
      mb   = fb + ((eb != 0) ? (1 << fw) : 0);
      abig = (effa > effb) || (effa == effb && ma >= mb);
      d    = abig ? effa - effb : effb - effa;
      if (d > cap) d = cap;
      bm   = abig ? ma : mb;
      smm  = abig ? mb : ma;
      bexp = abig ? effa : effb;
      na   = (ea == 255) && (fa != 0);
      nb   = (eb == 255) && (fb != 0);
      r.nan[l]  = na || nb;
      r.inf[l]  = !(na || nb) && ((ea == 255) || (eb == 255));
      r.sign[l] = abig ? sa[0] : sbv[0];
      r.eff[l]  = sa[0] ^ sbv[0];
      r.s  = r.s  | 8'(d << (4 * l));
      r.x  = r.x  | 24'(smm << (16 * l));
      r.bf = r.bf | 24'(bm << (16 * l));
      r.be = r.be | 16'(bexp << (8 * l));
    end
    return r;
  endfunction

  task automatic tick();
    beat_t e;
    @(negedge clk);
    snap_valid = out_valid; snap_in_ready = in_ready;
    snap_x = out_x; snap_s = out_s; snap_bf = out_big_frac; snap_be = out_big_exp;
    snap_sign = out_sign; snap_eff = out_eff_sub; snap_nan = out_nan; snap_inf = out_inf;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb_q[0];
        chk("fmt",  32'(out_fmt),      32'(e.fmt));
        chk("x",    32'(out_x),        32'(e.x));
        chk("s",    32'(out_s),        32'(e.s));
        chk("bfrac",32'(out_big_frac), 32'(e.bf));
        chk("bexp", 32'(out_big_exp),  32'(e.be));
        chk("sign", 32'(out_sign),     32'(e.sign));
        chk("eff",  32'(out_eff_sub),  32'(e.eff));
        chk("nan",  32'(out_nan),      32'(e.nan));
        chk("inf",  32'(out_inf),      32'(e.inf));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
    if (in_valid && in_ready) sb_q.push_back(model(in_fmt == FP16, in_a, in_b, in_sub));
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic fmt, input logic [31:0] a, input logic [31:0] b,
                         input logic sub);
    in_fmt = fmt ? FP16 : FP32; in_a = a; in_b = b; in_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("one_in_ready", 32'(snap_in_ready), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("lat_cycle1", 32'(snap_valid), 32'd0);
    tick();
    chk("lat_cycle2", 32'(snap_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int idx, n;
    logic [31:0] bp_a [4];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("rst_out_valid", 32'(snap_valid), 32'd0);
    chk("rst_in_ready",  32'(snap_in_ready), 32'd1);
    chk("rst_out_x",     32'(snap_x), 32'd0);
    chk("rst_out_bexp",  32'(snap_be), 32'd0);
    chk("rst_out_fmt",   32'(out_fmt), 32'(FP32));

    run_one(1'b0, 32'h3F800000, 32'h3F000000, 1'b0);
    chk("t1_bexp", 32'(snap_be), 32'h007F);
    chk("t1_s",    32'(snap_s), 32'h01);
    chk("t1_x",    32'(snap_x), 32'h800000);
    chk("t1_bf",   32'(snap_bf), 32'h800000);
    chk("t1_eff",  32'(snap_eff), 32'd0);
    chk("t1_sign", 32'(snap_sign), 32'd0);

    run_one(1'b0, 32'h3F000000, 32'h40000000, 1'b1);
    chk("t2_bexp", 32'(snap_be), 32'h0080);
    chk("t2_s",    32'(snap_s), 32'h02);
    chk("t2_sign", 32'(snap_sign[0]), 32'd1);
    chk("t2_eff",  32'(snap_eff[0]), 32'd1);

    run_one(1'b0, 32'h7F000000, 32'h00800000, 1'b0);
    chk("t3_clamp", 32'(snap_s), 32'h1F);

    run_one(1'b1, 32'h3F804000, 32'h3F003F80, 1'b0);
    chk("t4_s",    32'(snap_s), 32'h11);
    chk("t4_x",    32'(snap_x), 32'h800080);
    chk("t4_bexp", 32'(snap_be), 32'h7F80);

    run_one(1'b1, 32'h3F804000, 32'h3F800080, 1'b0);
    chk("t5_lo_clamp", 32'(snap_s[3:0]), 32'hF);

    run_one(1'b0, 32'h7FC00000, 32'h3F800000, 1'b0);
    chk("t6_nan", 32'(snap_nan[0]), 32'd1);

    run_one(1'b1, 32'h7F803F80, 32'h3F803F80, 1'b0);
    chk("t7_inf", 32'(snap_inf), 32'h2);

    // Backpressure: four beats offered against a stalled sink.
    bp_a[0] = 32'h3F800000; bp_a[1] = 32'h40400000;
    bp_a[2] = 32'h3F803F80; bp_a[3] = 32'hC1200000;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_fmt = (idx == 2) ? FP16 : FP32;
      in_a = bp_a[idx]; in_b = 32'h3E800000 + 32'(idx); in_sub = idx[0];
      in_valid = 1'b1;
      tick();
      chk("bp_in_ready", 32'(snap_in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (snap_in_ready) idx++;
    end
    out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      in_fmt = (idx == 2) ? FP16 : FP32;
      in_a = bp_a[idx]; in_b = 32'h3E800000 + 32'(idx); in_sub = idx[0];
      tick();
      if (n == 0) chk("full_push_pop", 32'(snap_in_ready), 32'd1);
      if (snap_in_ready) idx++;
      n++;
    end
    chk("bp_all_pushed", 32'(idx), 32'd4);
    in_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("bp_drained", 32'(sb_q.size()), 32'd0);
    tick();
    chk("bp_no_dup", 32'(snap_valid), 32'd0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_fmt    = $urandom_range(1) ? FP16 : FP32;
      in_sub    = $urandom_range(1) == 1;
      in_a      = $urandom;
      case ($urandom_range(7))
        0:       in_b = in_a;
        1:       in_b = in_a ^ ($urandom & 32'h807F807F);
        2:       in_b = $urandom & 32'h807F807F;
        3:       in_b = $urandom | 32'h7F807F80;
        default: in_b = $urandom;
      endcase
      if ($urandom_range(7) == 0) in_a = in_a | 32'h7F807F80;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("rand_drained", 32'(sb_q.size()), 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_fmt = FP16; in_a = 32'h3F804000; in_b = 32'h3F003F80; in_sub = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_x",     32'(out_x), 32'd0);
    chk("mid_rst_s",     32'(out_s), 32'd0);
    chk("mid_rst_bexp",  32'(out_big_exp), 32'd0);
    chk("mid_rst_fmt",   32'(out_fmt), 32'(FP32));
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) chk("post_rst_in_ready", 32'(snap_in_ready), 32'd1);
      chk("post_rst_no_beat", 32'(snap_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_align_prep.md
# fp_add_align_prep

Pipelined alignment-preparation stage for the shared FP32 / dual-BF16 adder datapath. It accepts two packed operands and decodes them. It orders each lane by magnitude, computes and clamps the exponent difference, and packs the smaller fraction and shift amount into the `X`/`S` layout that `barrel_shifter` consumes. The larger operand's exponent, fraction, sign and effective-operation flags pass alongside for the downstream add/normalize stage.

## Interface
Parameters: none (widths fixed by `fpall_pkg`).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_fmt`  in  fp_fmt_e  `FP32`, or `FP16` (two BF16 lanes)
- `in_a`, `in_b`  in  32 each  operands
  - FP32: IEEE single.
  - FP16 mode: hi lane `[31:16]`, lo lane `[15:0]`.
- `in_sub`  in  1  operation is a−b; applies to both lanes
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_fmt`  out  fp_fmt_e  format of the output beat
- `out_x`  out  24  smaller-operand fraction, in barrel_shifter `X` layout
- `out_s`  out  8  shift amount, in barrel_shifter `S` layout
- `out_big_frac`  out  24  larger-operand fraction, same layout as `out_x`
- `out_big_exp`  out  16
  - FP32: `[7:0]`, with `[15:8]`=0.
  - FP16: hi `[15:8]`, lo `[7:0]`.
- `out_sign`  out  2  result sign per lane; FP32 uses `[0]` and drives `[1]`=0
- `out_eff_sub`  out  2  effective subtraction per lane
- `out_nan`  out  2  a lane operand is NaN
- `out_inf`  out  2  a lane operand is Inf and neither is NaN

## Operation
- Decode, per lane. Let E be the exponent field (8 bits in both formats).
  - Effective exponent = E, or 1 when E = 0 (subnormal).
  - Hidden bit = (E ≠ 0).
  - FP32 mantissa: `{hidden, m[22:0]}`, 24 bits.
  - BF16 mantissa: `{hidden, m[6:0]}`, 8 bits.
- Sign of b is inverted when `in_sub`=1.
- Eff_sub = sa ^ sb', where sb' is the possibly inverted sign of b.
- Ordering: a is "big" if `{Ea_eff, Ma} >= {Eb_eff, Mb}`; otherwise b is big.
  - Ties select a.
  - Result sign = sign of big. Exact-cancellation sign is resolved downstream.
- diff = Ebig_eff − Esmall_eff, never negative.
- FP32 packing:
  - `out_s` = `{3'b0, min(diff,31)}`.
  - `out_x` = small mantissa.
  - `out_big_frac` = big mantissa.
  - `out_big_exp[7:0]` = big effective exponent.
- FP16 packing:
  - `out_s` = `{min(diff_hi,15), min(diff_lo,15)}`.
  - `out_x` = `{small_hi[7:0], 8'b0, small_lo[7:0]}`; the 8-bit gap must be zero.
  - `out_big_frac` uses the same packing.
- Specials: `out_nan` and `out_inf` are computed per lane; the numeric fields are still computed normally.
- Pipeline: two register stages.
  - S1 registers decoded fields and the compare result.
  - S2 registers the swap, clamped diff and packed outputs.
  - Each stage has its own valid bit.
- Load enables:
  - `s2_en` = `!s2_valid | out_ready`.
  - `s1_en` = `!s1_valid | s2_en`.
  - `in_ready` = `s1_en`; combinational from `out_ready` and the valid bits only.
- A beat transfers when valid & ready. S1 advances into S2 when `s1_valid & s2_en`.

## Timing
- Latency: 2 cycles from input handshake to `out_valid` when unstalled. Throughput 1 beat/cycle.
- Reset: all valid bits 0, so `out_valid`=0.
  - `in_ready`=1 immediately after reset deassertion.
  - All data outputs reset to 0; `out_fmt` resets to `FP32`.
- Stall:
  - While `out_valid & !out_ready`, all `out_*` hold stable.
  - The pipeline holds at most 2 beats; `in_ready` drops only when both stages are full and `out_ready`=0.
- Simultaneous events: output pop and input push in the same cycle with both stages full proceeds with no bubble and no loss.
- Ordering: beats leave in arrival order. The format may change beat-to-beat without a drain.
- Reset mid-operation flushes in-flight beats; no output appears for them.
- Inputs are ignored when `in_valid`=0. Data registers may hold stale values, but `out_*` are don't-care while `out_valid`=0.

## Test plan
- FP32 1.0+0.5: a=0x3F800000, b=0x3F000000 -> after 2 cycles:
  - `out_big_exp`=0x007F, `out_s`=0x01, `out_x`=0x800000, `out_big_frac`=0x800000;
  - `out_eff_sub`=0, `out_sign`=0.
- FP32 swap, subtract, and clamp:
  - a=0x3F000000, b=0x40000000, `in_sub`=1 -> `out_big_exp`=0x0080, `out_s`=0x02, `out_sign[0]`=1, `out_eff_sub[0]`=1.
  - a=0x7F000000, b=0x00800000 -> `out_s`=0x1F (clamped).
- FP16 dual lane:
  - a=0x3F804000, b=0x3F003F80 -> `out_s`=0x11, `out_x`=0x800080 (gap zero), `out_big_exp`=0x7F80.
  - Lo lane b exp 0x01 vs a exp 0x80 -> lo shift = 0xF.
- Specials: a=0x7FC00000 (NaN), b=0x3F800000 -> `out_nan[0]`=1. FP16 a=0x7F80xxxx -> `out_inf[1]`=1 and `out_inf[0]`=0.
- Backpressure: push 4 beats back-to-back with `out_ready`=0 ->
  - `in_ready` drops after 2 beats are accepted;
  - outputs hold stable;
  - raising `out_ready` delivers beats in order with no duplication or loss.
- Reset: assert `rst` with 2 beats in flight -> `out_valid`=0 and outputs 0 at once; `in_ready`=1 after deassertion; no stale beat is emitted.
